// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Contents: access-size encoding (constants and enum), FSM state enum, and a helper
// that folds the reserved size code onto word accesses.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    SzByte = SIZE_BYTE,
    SzHalf = SIZE_HALF,
    SzWord = SIZE_WORD,
    SzRsvd = SIZE_RSVD
  } size_e;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StResp
  } state_e;

  // The reserved encoding behaves exactly like a word access.
  function automatic size_e norm_size(input logic [1:0] size);
    return (size == SIZE_RSVD) ? SzWord : size_e'(size);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of the core request/response handshake and the word-memory port.
// Modports:
//   slave  - the LSU: takes core requests and memory read data, drives responses and
//            the memory address/write strobe.
//   master - the environment (core + memory) seen from the other side.
interface lsu_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;

  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;

  logic            mem_we;
  logic [XLEN-1:0] mem_a;
  logic [XLEN-1:0] mem_wd;
  logic [XLEN-1:0] mem_rd;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane handling for the LSU.
// Ports:
//   size_i     - normalised access size (never SzRsvd)
//   lane_i     - low address bits; byte lane = lane_i, half lane = lane_i[1]
//   unsigned_i - zero-extend loads when 1, sign-extend otherwise
//   rd_i       - word read from memory
//   wdata_i    - store data (byte/half taken from the low bits)
//   load_o     - extracted and extended load result
//   merge_o    - rd_i with the addressed lanes replaced by store data
module lsu_align
  import lsu_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  lane_i,
  input  logic        unsigned_i,
  input  logic [31:0] rd_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sh  = {lane_i, 3'b000};
  assign half_sh  = {lane_i[1], 4'b0000};
  assign byte_sel = rd_i[byte_sh +: 8];
  assign half_sel = rd_i[half_sh +: 16];

  always_comb begin
    load_o  = rd_i;
    merge_o = wdata_i;
    case (size_i)
      SzByte: begin
        load_o                 = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
        merge_o                = rd_i;
        merge_o[byte_sh +: 8]  = wdata_i[7:0];
      end
      SzHalf: begin
        load_o                 = {{16{~unsigned_i & half_sel[15]}}, half_sel};
        merge_o                = rd_i;
        merge_o[half_sh +: 16] = wdata_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: turns one core request at a time into word-memory cycles.
//   load        : Idle -> Read -> Resp
//   word store  : Idle -> Write -> Resp
//   byte/half st: Idle -> Read (merge) -> Write -> Resp
// Ports:
//   clk     - clock, rising edge
//   reset_n - asynchronous active-low reset; aborts any operation in flight
//   bus     - lsu_if.slave: core request/response and word-memory port
// Build option: define LSU_MISALIGN_TRAP_EN to answer misaligned half/word accesses with
// resp_err=1 and no memory cycle; otherwise misaligned accesses use the containing word.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic   clk,
  input logic   reset_n,
  lsu_if.slave  bus
);

  state_e          state_q;
  logic [XLEN-1:0] addr_q;
  size_e           size_q;
  logic            we_q;
  logic            uns_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;
  logic            valid_q;
  logic            mem_we_q;
  logic [XLEN-1:0] mem_a_q;
  logic [XLEN-1:0] mem_wd_q;

  size_e           req_sz;
  logic            req_mis;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merge_data;

  assign req_sz = norm_size(bus.req_size);

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_mis = ((req_sz == SzHalf) && bus.req_addr[0]) ||
                   ((req_sz == SzWord) && (bus.req_addr[1:0] != 2'b00));
`else
  assign req_mis = 1'b0;
`endif

  lsu_align u_align (
    .size_i     (size_q),
    .lane_i     (addr_q[1:0]),
    .unsigned_i (uns_q),
    .rd_i       (bus.mem_rd),
    .wdata_i    (wdata_q),
    .load_o     (load_data),
    .merge_o    (merge_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      size_q   <= SzWord;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      mem_we_q <= 1'b0;
      mem_a_q  <= '0;
      mem_wd_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr;
            size_q  <= req_sz;
            we_q    <= bus.req_we;
            uns_q   <= bus.req_unsigned;
            wdata_q <= bus.req_wdata;
            if (req_mis) begin
              state_q <= StResp;
              valid_q <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else if (bus.req_we && (req_sz == SzWord)) begin
              state_q  <= StWrite;
              mem_we_q <= 1'b1;
              mem_a_q  <= {bus.req_addr[XLEN-1:2], 2'b00};
              mem_wd_q <= bus.req_wdata;
            end else begin
              // Loads and sub-word stores both need the current word first.
              state_q <= StRead;
              mem_a_q <= {bus.req_addr[XLEN-1:2], 2'b00};
            end
          end
        end
        StRead: begin
          if (we_q) begin
            state_q  <= StWrite;
            mem_we_q <= 1'b1;
            mem_wd_q <= merge_data;
          end else begin
            state_q <= StResp;
            rdata_q <= load_data;
            valid_q <= 1'b1;
            mem_a_q <= '0;
          end
        end
        StWrite: begin
          state_q  <= StResp;
          mem_we_q <= 1'b0;
          mem_a_q  <= '0;
          mem_wd_q <= '0;
          rdata_q  <= '0;
          valid_q  <= 1'b1;
        end
        StResp: begin
          if (bus.resp_ready) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_a      = mem_a_q;
  assign bus.mem_wd     = mem_wd_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: the driver computes each expected response from a byte-level
// memory model and queues it; an independent monitor checks every response as it appears.
module tb_lsu;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  lsu_if #(.XLEN(32)) bus ();

  lsu #(.XLEN(32)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          npulse;
    int          acc;
    int          pbase;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] dmem      [0:255];
  logic [31:0] model_mem [0:255];
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          pulses = 0;
  int          hs_cyc = 0;
  int          hold_cnt = 0;

  function automatic logic [31:0] fill_word(input int i);
    return (i * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Word-addressed memory with combinational read and edge write.
  assign bus.mem_rd = dmem[bus.mem_a[9:2]];
  initial begin
    for (int i = 0; i < 256; i++) dmem[i] = fill_word(i);
    dmem[4] = 32'h8899AABB;
    dmem[8] = 32'h11223344;
    forever begin
      @(posedge clk);
      if (bus.mem_we) dmem[bus.mem_a[9:2]] <= bus.mem_wd;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.mem_we) pulses <= pulses + 1;

  // Reference: byte-lane arithmetic on the model memory.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
    int eff, nb, off, wa;
    logic [31:0] w, val;
    logic mis;
    eff = (size == 2'b11) ? 2 : int'(size);
    nb  = 1 << eff;
    off = (eff == 0) ? int'(addr[1:0]) : (eff == 1) ? int'(addr[1]) * 2 : 0;
    wa  = int'(addr[9:2]);
    w   = model_mem[wa];
    mis = ((eff == 1) && addr[0]) || ((eff == 2) && (addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) begin
      e.rdata = 0; e.err = 1'b1; e.lat = 1; e.npulse = 0;
      return;
    end
`else
    if (mis) e.err = 1'b0;
`endif
    e.err = 1'b0;
    if (!we) begin
      val = 0;
      for (int i = 0; i < nb; i++) val[8*i +: 8] = w[8*(off+i) +: 8];
      if (!uns && (nb < 4) && val[8*nb-1])
        for (int i = nb; i < 4; i++) val[8*i +: 8] = 8'hFF;
      e.rdata = val; e.lat = 2; e.npulse = 0;
    end else begin
      for (int i = 0; i < nb; i++) w[8*(off+i) +: 8] = wdata[8*i +: 8];
      model_mem[wa] = w;
      e.rdata = 0; e.lat = (eff == 2) ? 2 : 3; e.npulse = 1;
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit track, output int acc);
    exp_t e;
    int n;
    n = 0;
    acc = -1;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk("req_ready_timeout", 32'(bus.req_ready), 32'd1);
      return;
    end
    if (track) model(we, size, uns, addr, wdata, e);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    acc = cyc;
    if (track) begin
      e.acc   = cyc;
      e.pbase = pulses;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  // Monitor: checks each response, its latency, stability under backpressure, and
  // drives resp_ready.
  initial begin
    bit          active;
    bit          rdy;
    logic [31:0] h_rd;
    logic        h_err;
    active = 0;
    bus.resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        active = 0;
        bus.resp_ready = 1'b0;
      end else if (bus.resp_valid) begin
        rdy = ($urandom % 4) != 0;
        if (hold_cnt > 0) begin
          rdy = 0;
          hold_cnt--;
        end
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 32'(bus.resp_valid), 32'd0);
          rdy = 1;
        end else begin
          if (!active) begin
            active = 1;
            h_rd   = bus.resp_rdata;
            h_err  = bus.resp_err;
            chk("latency", 32'(cyc - exp_q[0].acc + 1), 32'(exp_q[0].lat));
            chk("resp_rdata", bus.resp_rdata, exp_q[0].rdata);
            chk("resp_err", 32'(bus.resp_err), 32'(exp_q[0].err));
          end else begin
            chk("resp_hold", {bus.resp_rdata[30:0], bus.resp_err}, {h_rd[30:0], h_err});
          end
          chk("resp_quiet", {bus.mem_a[29:0], bus.req_ready, bus.mem_we} | bus.mem_wd, 32'd0);
          if (rdy) begin
            chk("mem_we_pulses", 32'(pulses - exp_q[0].pbase), 32'(exp_q[0].npulse));
            void'(exp_q.pop_front());
            active = 0;
            hs_cyc = cyc + 1;
          end
        end
        bus.resp_ready = rdy;
      end else begin
        bus.resp_ready = 1'($urandom % 2);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, p0, bad;
    logic [31:0] addr;
    for (int i = 0; i < 256; i++) model_mem[i] = fill_word(i);
    model_mem[4] = 32'h8899AABB;
    model_mem[8] = 32'h11223344;
    bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_unsigned = 0;
    bus.req_addr = 0; bus.req_wdata = 0;

    #12;
    chk("rst_outputs", {bus.mem_a[28:0], bus.resp_valid, bus.resp_err, bus.mem_we}
                       | bus.resp_rdata | bus.mem_wd, 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed cases.
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, acc);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1, acc);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1, acc);
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234BEEF, 1, acc);
    drain();
    chk("half_merge_word", dmem[8], 32'hBEEF3344);
    do_req(1'b0, 2'b11, 1'b0, 32'hFFFF_FFFC, 32'h0, 1, acc);
    do_req(1'b1, 2'b10, 1'b0, 32'h21, 32'hCAFEF00D, 1, acc);
    drain();

    // Backpressure, then back-to-back acceptance right after the handshake.
    hold_cnt = 5;
    do_req(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 1, acc);
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1, acc2);
    chk("accept_after_hs", 32'(acc2), 32'(hs_cyc + 1));
    drain();

    // Reset during the Read of a byte store.
    p0 = pulses;
    do_req(1'b1, 2'b00, 1'b0, 32'h31, 32'hA5A5A5A5, 0, acc);
    reset_n = 1'b0;
    #1;
    chk("abort_outputs", {bus.mem_a[28:0], bus.resp_valid, bus.resp_err, bus.mem_we}
                         | bus.resp_rdata | bus.mem_wd, 32'd0);
    chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk("abort_no_write", 32'(pulses - p0), 32'd0);
    chk("abort_mem_word", dmem[12], model_mem[12]);

    // Randomised traffic.
    for (int t = 0; t < 300; t++) begin
      addr = 32'($urandom_range(0, 1023));
      if ($urandom % 16 == 0) addr = 32'hFFFF_FFFC | 32'($urandom % 4);
      do_req(1'($urandom), 2'($urandom), 1'($urandom), addr, $urandom, 1, acc);
    end
    drain();

    bad = 0;
    for (int i = 0; i < 256; i++) if (dmem[i] !== model_mem[i]) bad++;
    chk("mem_final_bad_words", 32'(bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data and address width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have core-request ports:
- req_valid, input, 1 bit
- req_ready, output, 1 bit
- req_we, input, 1 bit: 1 = store
- req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 reserved
- req_unsigned, input, 1 bit: zero-extend loads
- req_addr, input, 32 bits
- req_wdata, input, 32 bits
REQ-005 SHALL have core-response ports:
- resp_valid, output, 1 bit
- resp_ready, input, 1 bit
- resp_rdata, output, 32 bits
- resp_err, output, 1 bit
REQ-006 SHALL have word-memory ports:
- mem_we, output, 1 bit
- mem_a, output, 32 bits: byte address, bits [1:0] always 0
- mem_wd, output, 32 bits
- mem_rd, input, 32 bits: combinational read data for mem_a; the write occurs on the clk edge when mem_we=1

Function
REQ-007 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready=1 only in IDLE.
REQ-008 SHALL accept a request on the clk edge with req_valid&&req_ready, registering addr, size, we, unsigned and wdata.
REQ-009 Load path SHALL run IDLE->READ->RESP: in READ, mem_a=word address, mem_we=0, and the extracted, extended byte/half/word is registered into resp_rdata; resp_valid rises 2 cycles after acceptance.
REQ-010 Byte lane SHALL be addr[1:0] for bytes and addr[1]*2 for halves; signed loads sign-extend and req_unsigned=1 zero-extends.
REQ-011 Word store SHALL run IDLE->WRITE->RESP: mem_we=1 for exactly one cycle, mem_wd=wdata, and resp_valid rises 2 cycles after acceptance.
REQ-012 Byte/half store SHALL run IDLE->READ->WRITE->RESP: READ registers mem_rd with the addressed lanes replaced by wdata[7:0]/[15:0], WRITE writes the merged word, and resp_valid rises 3 cycles after acceptance.
REQ-013 resp_valid SHALL hold, with resp_rdata and resp_err stable, until resp_valid&&resp_ready; the FSM then returns to IDLE, and the next request is accepted no earlier than the following cycle.
REQ-014 resp_rdata SHALL be 0 for stores.
REQ-015 mem_we SHALL be 1 only in WRITE, and mem_a/mem_wd SHALL be 0 in IDLE and RESP.
REQ-016 req_size=11 SHALL be treated as word.
REQ-017 mem_a SHALL be the address truncated to 32 bits with no wrap detection; 0xFFFFFFFC is a legal word.

Reset
REQ-018 reset_n low SHALL force IDLE immediately (asynchronously): resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_a=0, mem_wd=0, req_ready=1.
REQ-019 Reset asserted mid-operation SHALL abort the operation with no memory write after assertion and no response delivered.

Configuration
REQ-020 Macro LSU_MISALIGN_TRAP_EN:
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, goes IDLE->RESP with resp_err=1, resp_rdata=0, no memory cycle, and resp_valid 1 cycle after acceptance.
- Undefined: resp_err is tied 0, low address bits are ignored for lane selection beyond the access size, and misaligned accesses use the containing aligned word.

Structure
REQ-021 Package lsu_pkg SHALL hold the size encoding enum, the FSM state enum, and the SIZE_* constants.
REQ-022 Sub-module lsu_align SHALL hold the combinational lane extract/extend for loads and the lane merge for stores.

Verification
REQ-023 Load word: dmem[0x10]=0x8899AABB, load word at addr 0x10 -> resp_valid at cycle +2, resp_rdata=0x8899AABB.
REQ-024 Signed and unsigned byte: load byte at 0x13, signed -> 0xFFFFFF88; same with req_unsigned=1 -> 0x00000088.
REQ-025 Half store merge: word 0x11223344 at 0x20, store half 0xBEEF at 0x22 -> exactly one mem_we pulse, word becomes 0xBEEF3344, resp_valid at cycle +3.
REQ-026 Backpressure: resp_ready=0 for 5 cycles -> resp_valid and resp_rdata hold, req_ready=0 throughout; a new request is accepted the cycle after the handshake.
REQ-027 Reset abort: reset_n low during the READ of a byte store -> no mem_we, all outputs at reset values, and the memory word is unchanged.
REQ-028 With LSU_MISALIGN_TRAP_EN: word store at 0x21 -> resp_err=1 at cycle +1, no mem_we.
